// File: rtl/text_pkg.sv
// Shared definitions for the line-text streamer: FSM state encoding,
// the space character, and the bit positions of the line_mapper entry
// fields {word_count, start_addr}.
package text_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAP_REQ,
    MAP_WAIT,
    ROM_REQ,
    ROM_WAIT,
    EMIT_HI,
    EMIT_LO,
    FIN
  } state_e;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int MAP_CNT_MSB  = 15;
  localparam int MAP_CNT_LSB  = 8;
  localparam int MAP_ADDR_MSB = 7;
  localparam int MAP_ADDR_LSB = 0;

endpackage

// File: rtl/char_word_splitter.sv
// Holds one fetched 16-bit ROM word and presents it as two characters
// (hi byte first, then lo byte) on a valid/ready interface.
// Optional feature macro: TRIM_SPACE_EN -- when defined, a trailing space
// in the lo byte of the line's last word is dropped and the hi byte of that
// word carries the last flag instead.
module char_word_splitter
  import text_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,       // capture word_i and start with the hi byte
  input  logic [15:0] word_i,
  input  logic        last_word_i,  // word_i is the final word of the line
  input  logic        ready_i,
  output logic [7:0]  char_data_o,
  output logic        char_valid_o,
  output logic        char_last_o,
  output logic        word_end_o    // final char of this word accepted this cycle
);

  logic [15:0] word_q;
  logic        last_word_q;
  logic        sel_lo_q;
  logic        valid_q;
  logic        accept;
  logic        trim_end;

  assign accept = valid_q & ready_i;

`ifdef TRIM_SPACE_EN
  // The hi byte ends the word when the last word's lo byte is a space.
  assign trim_end = last_word_q & (word_q[7:0] == CHAR_SPACE);
`else
  assign trim_end = 1'b0;
`endif

  // Word capture and hi/lo byte sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the word holding register is reset (unlike a RAM array) because
      // char_data is driven straight from it and must read 0 out of reset.
      word_q      <= '0;
      last_word_q <= 1'b0;
      sel_lo_q    <= 1'b0;
      valid_q     <= 1'b0;
    end else if (load_i) begin
      word_q      <= word_i;
      last_word_q <= last_word_i;
      sel_lo_q    <= 1'b0;
      valid_q     <= 1'b1;
    end else if (accept) begin
      if (!sel_lo_q && !trim_end) begin
        sel_lo_q <= 1'b1;
      end else begin
        valid_q  <= 1'b0;
      end
    end
  end

  // Outputs depend on registers only, so they stay stable under back-pressure.
  assign char_data_o  = sel_lo_q ? word_q[7:0] : word_q[15:8];
  assign char_valid_o = valid_q;
  assign char_last_o  = valid_q & last_word_q & (sel_lo_q | trim_end);
  assign word_end_o   = accept & (sel_lo_q | trim_end);

endmodule

// File: rtl/line_text_streamer.sv
// Line-text reader: on start, looks up {word_count, start_addr} for the
// requested line in line_mapper, fetches word_count 16-bit words from
// memory_chars and streams them out one character per handshake.
// Both ROMs are registered with one cycle of read latency.
// Optional feature macro: TRIM_SPACE_EN (implemented in char_word_splitter).
module line_text_streamer
  import text_pkg::*;
#(
  parameter int LINE_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LINE_W-1:0] line,
  output logic [LINE_W-1:0] map_line,
  input  logic [15:0]       map_entry,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        char_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              char_last,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic [LINE_W-1:0] map_line_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] addr_ptr_q;
  logic [ADDR_W-1:0] addr_ptr_d;
  logic [CNT_W-1:0]  words_left_q;
  logic              busy_q;
  logic              done_q;

  logic [CNT_W-1:0]  map_cnt;
  logic [ADDR_W-1:0] map_addr;
  logic              load_word;
  logic              last_word;
  logic              accept;
  logic              word_end;

  assign map_cnt    = map_entry[MAP_CNT_MSB:MAP_CNT_LSB];
  assign map_addr   = map_entry[MAP_ADDR_MSB:MAP_ADDR_LSB];
  // Pointer wraps naturally at 2^ADDR_W.
  assign addr_ptr_d = addr_ptr_q + ADDR_W'(1);
  assign load_word  = (state_q == ROM_WAIT);
  // words_left still counts the word being loaded at this point.
  assign last_word  = (words_left_q == CNT_W'(1));
  assign accept     = char_valid & char_ready;

  // Sequencer: mapper lookup, word fetch loop, completion pulse.
  // rom_addr is loaded on the edge that enters ROM_REQ so the ROM registers
  // the word at the end of ROM_REQ and it is captured at the end of ROM_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      map_line_q   <= '0;
      rom_addr_q   <= '0;
      addr_ptr_q   <= '0;
      words_left_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge value of each register regardless of statement order.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            map_line_q <= line;
            busy_q     <= 1'b1;
            state_q    <= MAP_REQ;
          end
        end
        MAP_REQ: state_q <= MAP_WAIT;
        MAP_WAIT: begin
          words_left_q <= map_cnt;
          addr_ptr_q   <= map_addr;
          rom_addr_q   <= map_addr;
          if (map_cnt == '0) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            state_q <= ROM_REQ;
          end
        end
        ROM_REQ: state_q <= ROM_WAIT;
        ROM_WAIT: begin
          addr_ptr_q   <= addr_ptr_d;
          words_left_q <= words_left_q - CNT_W'(1);
          state_q      <= EMIT_HI;
        end
        EMIT_HI: begin
          if (word_end) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else if (accept) begin
            state_q <= EMIT_LO;
          end
        end
        EMIT_LO: begin
          if (accept) begin
            if (words_left_q != '0) begin
              rom_addr_q <= addr_ptr_q;
              state_q    <= ROM_REQ;
            end else begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  char_word_splitter u_splitter (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load_word),
    .word_i       (rom_data),
    .last_word_i  (last_word),
    .ready_i      (char_ready),
    .char_data_o  (char_data),
    .char_valid_o (char_valid),
    .char_last_o  (char_last),
    .word_end_o   (word_end)
  );

  assign map_line = map_line_q;
  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
